fifo_wr_arbiter: RTL

- Shares one synchronous 8-bit FIFO write port between NUM_REQ producer ports.
- Uses round-robin arbitration with bounded bursts.
- Drives the FIFO write strobe and write data from registers.
- Blocks on FIFO occupancy so that no write is ever issued while the FIFO is full.

---
 rtl/fifo_wr_arbiter_if.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO write-port bundle for fifo_wr_arbiter.
// stall_cnt is carried only when FIFO_ARB_STATS_EN is defined.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data;
    logic [NUM_REQ-1:0]        gnt;
    logic [CNT_W-1:0]          fifo_count;
    logic                      fifo_write;
    logic [DATA_W-1:0]         fifo_din;
    logic                      busy;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0]               stall_cnt;
`endif

    modport master (
        input  req, data, fifo_count,
        output gnt, fifo_write, fifo_din, busy
`ifdef FIFO_ARB_STATS_EN
        , output stall_cnt
`endif
    );

    modport slave (
        output req, data, fifo_count,
        input  gnt, fifo_write, fifo_din, busy
`ifdef FIFO_ARB_STATS_EN
        , input stall_cnt
`endif
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-limited arbiter sharing one FIFO write port.
// Optional stall statistics counter enabled by FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int CNT_W     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_wr_arbiter_if.master     bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BC_W  = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       owner;
    logic [BC_W-1:0]        burst_cnt;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W-1:0]       next_ptr;
    logic                   space;
    logic                   grant;
    logic                   rotate;
    logic                   others;
    logic                   found;
    logic [NUM_REQ-1:0]     gnt_c;
    logic [DATA_W-1:0]      lane [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane[i] = bus.data[i*DATA_W +: DATA_W];
    end

    // The strobe in flight counts as occupied: the FIFO count lags it by one cycle.
    assign space = ({1'b0, bus.fifo_count} + {{CNT_W{1'b0}}, bus.fifo_write})
                   < (CNT_W+1)'(DEPTH);

    assign others   = |(bus.req & ~(NUM_REQ'(1) << owner));
    assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

    always_comb begin
        int               idx;
        logic [IDX_W-1:0] cand;
        idx     = 0;
        cand    = '0;
        sel_idx = '0;
        found   = 1'b0;
        grant   = 1'b0;
        rotate  = 1'b0;
        if (state == IDLE) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                cand = IDX_W'(idx);
                if (!found && bus.req[cand]) begin
                    found   = 1'b1;
                    sel_idx = cand;
                end
            end
            grant = found && space;
        end else begin
            sel_idx = owner;
            if (bus.req[owner] && space &&
                (burst_cnt < BC_W'(MAX_BURST) || !others)) begin
                grant = 1'b1;
            end else if (!bus.req[owner] ||
                         (burst_cnt == BC_W'(MAX_BURST) && others)) begin
                rotate = 1'b1;
            end
        end
        gnt_c = grant ? (NUM_REQ'(1) << sel_idx) : '0;
    end

    assign bus.gnt = rst ? gnt_c : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            burst_cnt      <= '0;
            bus.fifo_write <= 1'b0;
            bus.fifo_din   <= '0;
            bus.busy       <= 1'b0;
`ifdef FIFO_ARB_STATS_EN
            bus.stall_cnt  <= '0;
`endif
        end else begin
            bus.fifo_write <= grant;
            if (grant) bus.fifo_din <= lane[sel_idx];
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner     <= sel_idx;
                        burst_cnt <= BC_W'(1);
                        state     <= BURST;
                        bus.busy  <= 1'b1;
                    end
                end
                BURST: begin
                    if (grant) begin
                        if (burst_cnt != BC_W'(MAX_BURST))
                            burst_cnt <= burst_cnt + BC_W'(1);
                    end else if (rotate) begin
                        rr_ptr   <= next_ptr;
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
`ifdef FIFO_ARB_STATS_EN
            if ((|bus.req) && !space && bus.stall_cnt != 16'hFFFF)
                bus.stall_cnt <= bus.stall_cnt + 16'd1;
`endif
        end
    end
endmodule
